// File: rtl/vfp_frame_tagger_if.sv
// Stream bundle of the VFP frame tagger: raw camera stream in, tagged pixel stream and geometry status out.
interface vfp_frame_tagger_if;
    logic        iValid;
    logic        iLvalid;
    logic        iFvalid;
    logic [23:0] iRgb;
    logic        iErrClr;
    logic        oValid;
    logic        oLvalid;
    logic        oFvalid;
    logic        oSof;
    logic        oEof;
    logic [23:0] oRgb;
    logic [7:0]  oRed;
    logic [7:0]  oGreen;
    logic [7:0]  oBlue;
    logic [11:0] oX;
    logic [11:0] oY;
    logic [15:0] oFrameCnt;
    logic [11:0] oLastLineLen;
    logic [11:0] oLastLineCnt;
    logic [2:0]  oErr;

    modport master (
        output iValid, iLvalid, iFvalid, iRgb, iErrClr,
        input  oValid, oLvalid, oFvalid, oSof, oEof, oRgb, oRed, oGreen, oBlue,
        input  oX, oY, oFrameCnt, oLastLineLen, oLastLineCnt, oErr
    );

    modport slave (
        input  iValid, iLvalid, iFvalid, iRgb, iErrClr,
        output oValid, oLvalid, oFvalid, oSof, oEof, oRgb, oRed, oGreen, oBlue,
        output oX, oY, oFrameCnt, oLastLineLen, oLastLineCnt, oErr
    );
endinterface

// File: rtl/vfp_frame_tagger.sv
// Front end of the VFP pixel pipe: aligns the raw stream to frame boundaries, tags pixels with
// sof/eof/x/y and measures line length and line count per frame with sticky geometry errors.
module vfp_frame_tagger #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64
) (
    input  logic               clkmm,
    input  logic               rst,
    vfp_frame_tagger_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [11:0] W_LEN  = 12'(IMG_WIDTH);
    localparam logic [11:0] H_LEN  = 12'(IMG_HEIGHT);
    localparam logic [11:0] W_LAST = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] H_LAST = 12'(IMG_HEIGHT - 1);
    localparam logic [11:0] CNT_MAX = 12'hFFF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_lvalid_d;
    logic [11:0] r_x_cnt;
    logic [11:0] r_y_cnt;
    logic        r_sof_done;

    logic        r_valid;
    logic        r_lvalid_o;
    logic        r_fvalid_o;
    logic        r_sof;
    logic        r_eof;
    logic [23:0] r_rgb;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic [15:0] r_frame_cnt;
    logic [11:0] r_last_len;
    logic [11:0] r_last_cnt;
    logic [2:0]  r_err;

    logic        w_in_frame;
    logic        w_accept;
    logic        w_stray;
    logic        w_line_end;
    logic        w_frame_end;
    logic [11:0] w_x_inc;
    logic [11:0] w_y_inc;
    logic [11:0] w_y_final;
    logic [2:0]  w_err_set;

    // The cycle that raises iFvalid out of IDLE already belongs to the frame.
    assign w_in_frame  = (r_state == ST_ACTIVE) || ((r_state == ST_IDLE) && bus.iFvalid);
    assign w_accept    = w_in_frame && bus.iValid && bus.iLvalid;
    assign w_stray     = w_in_frame && bus.iValid && !bus.iLvalid;
    assign w_line_end  = (r_state == ST_ACTIVE) && r_lvalid_d && !bus.iLvalid;
    assign w_frame_end = (r_state == ST_ACTIVE) && !bus.iFvalid;
    assign w_x_inc     = (r_x_cnt == CNT_MAX) ? CNT_MAX : (r_x_cnt + 12'd1);
    assign w_y_inc     = (r_y_cnt == CNT_MAX) ? CNT_MAX : (r_y_cnt + 12'd1);
    // A line closing together with the frame is counted before the frame total is taken.
    assign w_y_final   = w_line_end ? w_y_inc : r_y_cnt;
    assign w_err_set   = {w_stray,
                          w_frame_end && (w_y_final != H_LEN),
                          w_line_end && (r_x_cnt != W_LEN)};

    // Frame-alignment state register.
    always_ff @(posedge clkmm) begin
        if (rst) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; SYNC waits out any frame already running at reset release.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SYNC: begin
                if (!bus.iFvalid) w_state_nxt = ST_IDLE;
                else              w_state_nxt = ST_SYNC;
            end
            ST_IDLE: begin
                if (bus.iFvalid) w_state_nxt = ST_ACTIVE;
                else             w_state_nxt = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (!bus.iFvalid) w_state_nxt = ST_IDLE;
                else              w_state_nxt = ST_ACTIVE;
            end
            default: w_state_nxt = ST_SYNC;
        endcase
    end

    // Pixel/line position counters and first-pixel tracking.
    always_ff @(posedge clkmm) begin
        if (rst) begin
            r_lvalid_d <= 1'b0;
            r_x_cnt    <= 12'd0;
            r_y_cnt    <= 12'd0;
            r_sof_done <= 1'b0;
        end else begin
            r_lvalid_d <= bus.iLvalid;
            if (w_frame_end || (r_state == ST_SYNC)) begin
                r_x_cnt    <= 12'd0;
                r_y_cnt    <= 12'd0;
                r_sof_done <= 1'b0;
            end else begin
                if (w_line_end) begin
                    r_x_cnt <= 12'd0;
                    r_y_cnt <= w_y_inc;
                end else if (w_accept) begin
                    r_x_cnt <= w_x_inc;
                end
                if (w_accept) begin
                    r_sof_done <= 1'b1;
                end
            end
        end
    end

    // Tagged stream and geometry status, all one cycle behind the input sample.
    always_ff @(posedge clkmm) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_lvalid_o  <= 1'b0;
            r_fvalid_o  <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_rgb       <= 24'd0;
            r_x         <= 12'd0;
            r_y         <= 12'd0;
            r_frame_cnt <= 16'd0;
            r_last_len  <= 12'd0;
            r_last_cnt  <= 12'd0;
            r_err       <= 3'd0;
        end else begin
            r_valid    <= w_accept;
            r_lvalid_o <= bus.iLvalid && w_in_frame;
            r_fvalid_o <= bus.iFvalid && w_in_frame;
            r_sof      <= w_accept && !r_sof_done;
            r_eof      <= w_accept && (r_x_cnt == W_LAST) && (r_y_cnt == H_LAST);
            if (w_accept) begin
                r_x   <= r_x_cnt;
                r_y   <= r_y_cnt;
                r_rgb <= bus.iRgb;
            end
            if (w_line_end) begin
                r_last_len <= r_x_cnt;
            end
            if (w_frame_end) begin
                r_last_cnt  <= w_y_final;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            r_err <= (r_err & ~{3{bus.iErrClr}}) | w_err_set;
        end
    end

    assign bus.oValid       = r_valid;
    assign bus.oLvalid      = r_lvalid_o;
    assign bus.oFvalid      = r_fvalid_o;
    assign bus.oSof         = r_sof;
    assign bus.oEof         = r_eof;
    assign bus.oRgb         = r_rgb;
    assign bus.oRed         = r_rgb[23:16];
    assign bus.oGreen       = r_rgb[15:8];
    assign bus.oBlue        = r_rgb[7:0];
    assign bus.oX           = r_x;
    assign bus.oY           = r_y;
    assign bus.oFrameCnt    = r_frame_cnt;
    assign bus.oLastLineLen = r_last_len;
    assign bus.oLastLineCnt = r_last_cnt;
    assign bus.oErr         = r_err;
endmodule

// File: tb/tb_vfp_frame_tagger.sv
// Randomized bench for vfp_frame_tagger: frames are generated as line plans and the expected tagged
// stream is derived from frame geometry (pixel index, line index), then checked every cycle.
module tb_vfp_frame_tagger;
    localparam int W = 64;
    localparam int H = 64;

    logic clk = 1'b0;
    logic rst;
    vfp_frame_tagger_if bus ();

    vfp_frame_tagger #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clkmm (clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          v;
        int          x;
        int          y;
        logic [23:0] rgb;
        bit          sof;
        bit          eof;
        bit          lv;
        bit          fv;
    } exp_t;

    exp_t     q[$];
    int       cyc = 0;
    int       n_checks = 0;
    int       n_fail = 0;
    int       n_pix = 0;
    int       n_sof = 0;
    int       n_eof = 0;
    bit [2:0] m_err;
    int       m_frames;
    int       line_len[0:127];
    int       n_lines;
    int       density;
    bit       stray;
    bit       fall_tog;
    int       probe_line;
    int       probe_len;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Per-cycle comparison of the DUT outputs against the record due this cycle.
    task automatic check_due();
        exp_t        e;
        logic [76:0] got;
        logic [76:0] want;
        while (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL stream_record: record due at cycle %0d never compared (now %0d)", e.due, cyc);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            if (bus.oValid) n_pix++;
            if (bus.oSof)   n_sof++;
            if (bus.oEof)   n_eof++;
            got  = {bus.oValid, bus.oSof, bus.oEof, bus.oLvalid, bus.oFvalid, bus.oX, bus.oY,
                    bus.oRgb, bus.oRed, bus.oGreen, bus.oBlue};
            want = {e.v, e.sof, e.eof, e.lv, e.fv, 12'(e.x), 12'(e.y),
                    e.rgb, e.rgb[23:16], e.rgb[15:8], e.rgb[7:0]};
            if (!e.v) begin
                got[71:0]  = 72'd0;
                want[71:0] = 72'd0;
            end
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL stream cycle %0d: got v/sof/eof/lv/fv=%b%b%b%b%b x=%0d y=%0d rgb=%h expected %b%b%b%b%b x=%0d y=%0d rgb=%h",
                         cyc, bus.oValid, bus.oSof, bus.oEof, bus.oLvalid, bus.oFvalid, bus.oX, bus.oY, bus.oRgb,
                         e.v, e.sof, e.eof, e.lv, e.fv, e.x, e.y, e.rgb);
            end
        end
    endtask

    // One clock of stimulus plus the output it must produce one cycle later.
    task automatic tick(input bit r, input bit v, input bit lv, input bit fv, input logic [23:0] rgb,
                        input bit clr, input bit live, input bit ev, input int ex, input int ey,
                        input bit es, input bit ee);
        exp_t e;
        @(posedge clk);
        #1;
        check_due();
        rst         = r;
        bus.iValid  = v;
        bus.iLvalid = lv;
        bus.iFvalid = fv;
        bus.iRgb    = rgb;
        bus.iErrClr = clr;
        e.due = cyc + 1;
        e.v   = ev;
        e.x   = ex;
        e.y   = ey;
        e.rgb = rgb;
        e.sof = es;
        e.eof = ee;
        e.lv  = lv && live && !r;
        e.fv  = fv && live && !r;
        q.push_back(e);
        if (r) begin
            m_err    = 3'b000;
            m_frames = 0;
        end
        if (clr) m_err = 3'b000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic clear_err();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(1);
    endtask

    task automatic set_geom(input int lines, input int len);
        n_lines = lines;
        for (int i = 0; i < lines; i++) line_len[i] = len;
    endtask

    task automatic run_frame(input bit live);
        int          cnt;
        int          ex;
        int          ey;
        bit          pend_sof;
        bit          sv;
        logic [23:0] px;
        pend_sof = live;
        tick(1'b0, 1'b0, 1'b0, 1'b1, 24'($urandom), 1'b0, live, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int l = 0; l < n_lines; l++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1, 24'($urandom), 1'b0, live, 1'b0, 0, 0, 1'b0, 1'b0);
            cnt = 0;
            while (cnt < line_len[l]) begin
                px = 24'($urandom);
                if ($urandom_range(99) < density) begin
                    ex = (cnt > 4095) ? 4095 : cnt;
                    ey = (l > 4095) ? 4095 : l;
                    tick(1'b0, 1'b1, 1'b1, 1'b1, px, 1'b0, live, live, ex, ey,
                         live && pend_sof, live && (ex == W - 1) && (ey == H - 1));
                    pend_sof = 1'b0;
                    cnt++;
                end else begin
                    tick(1'b0, 1'b0, 1'b1, 1'b1, px, 1'b0, live, 1'b0, 0, 0, 1'b0, 1'b0);
                end
            end
            if (!((l == n_lines - 1) && fall_tog)) begin
                sv = stray && ((l % 7) == 3);
                tick(1'b0, sv, 1'b0, 1'b1, 24'($urandom), sv, live, 1'b0, 0, 0, 1'b0, 1'b0);
                if (live) begin
                    if (line_len[l] != W) m_err[0] = 1'b1;
                    if (sv) m_err[2] = 1'b1;
                end
                tick(1'b0, 1'b0, 1'b0, 1'b1, 24'($urandom), 1'b0, live, 1'b0, 0, 0, 1'b0, 1'b0);
                if (live) begin
                    chk("line_len", int'(bus.oLastLineLen), (line_len[l] > 4095) ? 4095 : line_len[l]);
                    chk("line_err0", int'(bus.oErr[0]), int'(m_err[0]));
                    if (l == probe_line) probe_len = int'(bus.oLastLineLen);
                end
            end
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0, live, 1'b0, 0, 0, 1'b0, 1'b0);
        if (live) begin
            if (fall_tog && line_len[n_lines - 1] != W) m_err[0] = 1'b1;
            if (n_lines != H) m_err[1] = 1'b1;
            m_frames++;
        end
        idle(1);
        if (live) begin
            chk("frame_line_cnt", int'(bus.oLastLineCnt), n_lines);
            chk("frame_last_len", int'(bus.oLastLineLen),
                (line_len[n_lines - 1] > 4095) ? 4095 : line_len[n_lines - 1]);
            chk("frame_cnt", int'(bus.oFrameCnt), m_frames & 16'hFFFF);
            chk("frame_err", int'(bus.oErr), int'(m_err));
        end
    endtask

    initial begin
        int p0;
        int s0;
        int e0;
        rst         = 1'b1;
        bus.iValid  = 1'b0;
        bus.iLvalid = 1'b0;
        bus.iFvalid = 1'b0;
        bus.iRgb    = 24'd0;
        bus.iErrClr = 1'b0;
        m_err       = 3'b000;
        m_frames    = 0;
        probe_line  = -1;
        probe_len   = 0;
        density     = 100;
        stray       = 1'b0;
        fall_tog    = 1'b0;

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(1);
        chk("rst_valid", int'(bus.oValid), 0);
        chk("rst_frame_cnt", int'(bus.oFrameCnt), 0);
        chk("rst_err", int'(bus.oErr), 0);
        chk("rst_xy", int'({bus.oX, bus.oY}), 0);
        chk("rst_rgb", int'(bus.oRgb), 0);
        chk("rst_geom", int'({bus.oLastLineLen, bus.oLastLineCnt}), 0);
        idle(2);

        // Clean 64x64 frame at full rate.
        set_geom(64, 64);
        p0 = n_pix; s0 = n_sof; e0 = n_eof;
        run_frame(1'b1);
        chk("full_pixels", n_pix - p0, 4096);
        chk("full_sof", n_sof - s0, 1);
        chk("full_eof", n_eof - e0, 1);
        chk("full_frame_cnt", int'(bus.oFrameCnt), 1);
        chk("full_err", int'(bus.oErr), 0);
        chk("full_line_cnt", int'(bus.oLastLineCnt), 64);

        // Short line 10.
        clear_err();
        set_geom(64, 64);
        line_len[10] = 63;
        probe_line = 10;
        run_frame(1'b1);
        chk("short_line_len", probe_len, 63);
        chk("short_line_err", int'(bus.oErr), 1);
        probe_line = -1;

        // 65 lines, then clear the sticky flag.
        clear_err();
        set_geom(65, 64);
        e0 = n_eof;
        run_frame(1'b1);
        chk("tall_line_cnt", int'(bus.oLastLineCnt), 65);
        chk("tall_err", int'(bus.oErr), 2);
        chk("tall_eof", n_eof - e0, 1);
        clear_err();
        chk("err_clear", int'(bus.oErr), 0);

        // Gapped valid with stray pixels outside lvalid (clear pulsed on the same cycle).
        set_geom(64, 64);
        density = 33;
        stray = 1'b1;
        p0 = n_pix;
        run_frame(1'b1);
        chk("gap_pixels", n_pix - p0, 4096);
        chk("gap_err", int'(bus.oErr), 4);
        density = 100;
        stray = 1'b0;

        // Last line and frame valid fall on the same cycle.
        clear_err();
        set_geom(64, 64);
        fall_tog = 1'b1;
        run_frame(1'b1);
        chk("tog_line_cnt", int'(bus.oLastLineCnt), 64);
        chk("tog_err", int'(bus.oErr), 0);
        fall_tog = 1'b0;

        // Overlong line saturating the x counter.
        clear_err();
        set_geom(3, 64);
        line_len[1] = 4098;
        probe_line = 1;
        run_frame(1'b1);
        chk("long_line_len", probe_len, 4095);
        chk("long_err", int'(bus.oErr), 3);
        probe_line = -1;

        // Reset in the middle of a frame, released while iFvalid is still high.
        tick(1'b0, 1'b0, 1'b0, 1'b1, 24'($urandom), 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 24'($urandom), 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            logic [23:0] px;
            px = 24'($urandom);
            tick(1'b0, 1'b1, 1'b1, 1'b1, px, 1'b0, 1'b1, 1'b1, i, 0, i == 0, 1'b0);
        end
        tick(1'b1, 1'b1, 1'b1, 1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
        chk("midrst_frame_cnt", int'(bus.oFrameCnt), 0);
        chk("midrst_err", int'(bus.oErr), 0);
        set_geom(5, 64);
        p0 = n_pix;
        run_frame(1'b0);
        chk("midrst_dropped", n_pix - p0, 0);
        idle(2);
        set_geom(64, 64);
        p0 = n_pix; s0 = n_sof;
        run_frame(1'b1);
        chk("resync_frame_cnt", int'(bus.oFrameCnt), 1);
        chk("resync_pixels", n_pix - p0, 4096);
        chk("resync_sof", n_sof - s0, 1);

        // Randomized frames around the nominal geometry.
        for (int f = 0; f < 3; f++) begin
            clear_err();
            n_lines = $urandom_range(66, 62);
            for (int l = 0; l < n_lines; l++)
                line_len[l] = ($urandom_range(9) == 0) ? int'($urandom_range(68, 60)) : 64;
            density  = $urandom_range(100, 60);
            stray    = 1'($urandom_range(1));
            fall_tog = 1'($urandom_range(1));
            run_frame(1'b1);
            idle($urandom_range(4, 1));
        end

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
